// File: rtl/cpu_controller_if.sv
// Memory handshake between the CPU control unit and program/data memory.
// The controller is the master: it raises rd/wr and memory answers with ready.
interface cpu_controller_if;
  logic mem_rd;
  logic mem_wr;
  logic mem_ready;

  modport master (
    output mem_rd,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    output mem_ready
  );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Optional single-step mode is enabled with `define CPU_CTRL_STEP_EN.
module cpu_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CPU_CTRL_STEP_EN
  input  logic             i_step,
  output logic             o_paused,
`endif
  input  logic [1:0]       i_op_code,
  cpu_controller_if.master mem,
  output logic             o_ir_on_adr,
  output logic             o_pc_on_adr,
  output logic             o_ld_ir,
  output logic             o_ld_ac,
  output logic             o_ld_pc,
  output logic             o_inc_pc,
  output logic             o_clr_pc,
  output logic             o_pass_add,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_instr_count
);

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_LDA,
    S_ADD,
    S_STA,
    S_JMP,
`ifdef CPU_CTRL_STEP_EN
    S_PAUSE,
`endif
    S_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

`ifdef CPU_CTRL_STEP_EN
  localparam state_t S_AFTER = S_PAUSE;
`else
  localparam state_t S_AFTER = S_FETCH;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_waitCnt;
  logic [CNT_W-1:0] r_instrCount;
  logic             w_retire;
  logic             w_memState;
  logic             w_timeout;
  logic             w_stepRise;

`ifdef CPU_CTRL_STEP_EN
  logic r_stepPrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stepPrev <= 1'b0;
    else     r_stepPrev <= i_step;
  end

  assign w_stepRise = i_step & ~r_stepPrev;
`else
  assign w_stepRise = 1'b0;
`endif

  assign w_memState = (r_state == S_FETCH) || (r_state == S_LDA) || (r_state == S_STA);
  assign w_timeout  = (r_waitCnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  // Timeout on the cycle that would make the wait count reach MEM_TIMEOUT.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_RESET:  w_next = S_AFTER;
      S_FETCH: begin
        if (mem.mem_ready)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (i_op_code)
          2'b00:   w_next = S_LDA;
          2'b01:   w_next = S_ADD;
          2'b10:   w_next = S_STA;
          default: w_next = S_JMP;
        endcase
      end
      S_LDA, S_STA: begin
        if (mem.mem_ready) begin
          w_next   = S_AFTER;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_ADD, S_JMP: begin
        w_next   = S_AFTER;
        w_retire = 1'b1;
      end
`ifdef CPU_CTRL_STEP_EN
      S_PAUSE: if (w_stepRise) w_next = S_FETCH;
`endif
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_RESET;
    endcase
  end

  always_comb begin
    o_ir_on_adr = 1'b0;
    o_pc_on_adr = 1'b0;
    o_ld_ir     = 1'b0;
    o_ld_ac     = 1'b0;
    o_ld_pc     = 1'b0;
    o_inc_pc    = 1'b0;
    o_clr_pc    = 1'b0;
    o_pass_add  = 1'b0;
    o_fault     = 1'b0;
    mem.mem_rd  = 1'b0;
    mem.mem_wr  = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    o_paused    = 1'b0;
`endif
    if (rst) begin
      o_clr_pc = 1'b1;
    end else begin
      case (r_state)
        S_RESET:  o_clr_pc = 1'b1;
        S_FETCH: begin
          o_pc_on_adr = 1'b1;
          mem.mem_rd  = 1'b1;
          o_ld_ir     = mem.mem_ready;
        end
        S_DECODE: o_inc_pc = 1'b1;
        S_LDA: begin
          o_ir_on_adr = 1'b1;
          mem.mem_rd  = 1'b1;
          o_ld_ac     = mem.mem_ready;
        end
        S_ADD: begin
          o_pass_add = 1'b1;
          o_ld_ac    = 1'b1;
        end
        S_STA: begin
          o_ir_on_adr = 1'b1;
          mem.mem_wr  = 1'b1;
        end
        S_JMP:    o_ld_pc = 1'b1;
`ifdef CPU_CTRL_STEP_EN
        S_PAUSE:  o_paused = 1'b1;
`endif
        S_FAULT:  o_fault = 1'b1;
        default: ;
      endcase
    end
  end

  // Restart the wait count on every state change and on each acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_waitCnt <= 8'd0;
    else if ((w_next != r_state) || !w_memState || mem.mem_ready)
      r_waitCnt <= 8'd0;
    else
      r_waitCnt <= r_waitCnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instrCount <= '0;
    else if (w_retire) r_instrCount <= r_instrCount + CNT_W'(1);
  end

  assign o_instr_count = r_instrCount;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller with a small datapath/memory model
// and a scoreboard of expected architectural state at each retirement.
module tb_cpu_controller;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  typedef struct packed {
    logic [7:0]  ac;
    logic [5:0]  pc;
    logic [7:0]  mem7;
    logic [15:0] cnt;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_controller_if memBus();

  logic [1:0]       opCode;
  logic             irOnAdr, pcOnAdr, ldIr, ldAc, ldPc, incPc, clrPc, passAdd, fault;
  logic [CNT_W-1:0] instrCount;
  logic             readyDrive = 1'b1;
`ifdef CPU_CTRL_STEP_EN
  logic             step = 1'b0;
  logic             paused;
`endif

  logic [7:0]  rom    [64];
  logic [7:0]  wrMem  [64];
  logic [63:0] wrValid;
  logic [5:0]  pcM;
  logic [7:0]  irM;
  logic [7:0]  acM;
  logic [5:0]  adr;

  int          compared   = 0;
  int          mismatched = 0;
  expT         expQ[$];
  logic [CNT_W-1:0] lastCnt;

  cpu_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef CPU_CTRL_STEP_EN
    .i_step       (step),
    .o_paused     (paused),
`endif
    .i_op_code    (opCode),
    .mem          (memBus),
    .o_ir_on_adr  (irOnAdr),
    .o_pc_on_adr  (pcOnAdr),
    .o_ld_ir      (ldIr),
    .o_ld_ac      (ldAc),
    .o_ld_pc      (ldPc),
    .o_inc_pc     (incPc),
    .o_clr_pc     (clrPc),
    .o_pass_add   (passAdd),
    .o_fault      (fault),
    .o_instr_count(instrCount)
  );

`ifdef CPU_CTRL_STEP_EN
  always @(negedge clk) step <= paused & ~step;
`endif

  function automatic logic [7:0] memRead(input logic [5:0] a);
    return wrValid[a] ? wrMem[a] : rom[a];
  endfunction

  assign memBus.mem_ready = readyDrive;
  assign opCode = irM[7:6];
  assign adr    = irOnAdr ? irM[5:0] : pcM;

  // Datapath and memory model reacting to the controller strobes.
  always @(posedge clk) begin
    if (rst) wrValid <= '0;
    if (clrPc)      pcM <= 6'd0;
    else if (ldPc)  pcM <= irM[5:0];
    else if (incPc) pcM <= pcM + 6'd1;
    if (ldIr) irM <= memRead(adr);
    if (ldAc) acM <= passAdd ? acM + {2'b00, irM[5:0]} : memRead(adr);
    if (memBus.mem_wr && memBus.mem_ready) begin
      wrMem[adr]   <= acM;
      wrValid[adr] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int testId);
    expQ.delete();
    case (testId)
      1: begin
        expQ.push_back('{ac: 8'h2A, pc: 6'd1, mem7: 8'h00, cnt: 16'd1});
        expQ.push_back('{ac: 8'h2B, pc: 6'd2, mem7: 8'h00, cnt: 16'd2});
        expQ.push_back('{ac: 8'h2B, pc: 6'd3, mem7: 8'h2B, cnt: 16'd3});
        expQ.push_back('{ac: 8'h2B, pc: 6'd3, mem7: 8'h2B, cnt: 16'd4});
      end
      2: expQ.push_back('{ac: 8'h2A, pc: 6'd1, mem7: 8'h00, cnt: 16'd1});
      4: begin
        expQ.push_back('{ac: 8'h2A, pc: 6'd1, mem7: 8'h00, cnt: 16'd1});
        expQ.push_back('{ac: 8'h2B, pc: 6'd2, mem7: 8'h00, cnt: 16'd2});
      end
      default: ;
    endcase
  endtask

  task automatic doReset();
    rst        = 1'b1;
    readyDrive = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    lastCnt = '0;
    #1;
  endtask

  // One clock, sampled 1 time unit after the edge; pops the scoreboard on retire.
  task automatic stepCycle();
    expT e;
    @(posedge clk);
    #1;
    checkOutput("rdWrExcl", {31'd0, memBus.mem_rd & memBus.mem_wr}, 32'd0);
    checkOutput("adrExcl", {31'd0, irOnAdr & pcOnAdr}, 32'd0);
    if (instrCount != lastCnt) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("retireCnt", 32'(instrCount), 32'(e.cnt));
        checkOutput("retireAc", 32'(acM), 32'(e.ac));
        checkOutput("retirePc", 32'(pcM), 32'(e.pc));
        checkOutput("retireMem7", 32'(memRead(6'd7)), 32'(e.mem7));
      end else begin
        checkOutput("spuriousRetire", 32'(instrCount), 32'(lastCnt));
      end
      lastCnt = instrCount;
    end
  endtask

  initial begin
    int   budget;
    int   staCycles;
    logic sawLdPc;

    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = 8'h05;
    rom[1] = 8'h41;
    rom[2] = 8'h87;
    rom[3] = 8'hC3;
    rom[5] = 8'h2A;

    #1;
    checkOutput("resetClrPc", {31'd0, clrPc}, 32'd1);
    checkOutput("resetCount", 32'(instrCount), 32'd0);
    checkOutput("resetFault", {31'd0, fault}, 32'd0);

    $display("[TB] program run LDA/ADD/STA/JMP");
    applyStimulus(1);
    doReset();
    checkOutput("t1ResetCycle", {22'd0, irOnAdr, pcOnAdr, ldIr, ldAc, ldPc, incPc, clrPc, passAdd,
                                 memBus.mem_rd, memBus.mem_wr}, 32'h8);
    stepCycle();
    checkOutput("t1Fetch", {28'd0, pcOnAdr, memBus.mem_rd, ldIr, irOnAdr}, 32'hE);
    checkOutput("t1FetchAdr", 32'(adr), 32'd0);
    stepCycle();
    checkOutput("t1Decode", {29'd0, incPc, memBus.mem_rd, pcOnAdr}, 32'h4);
    stepCycle();
    checkOutput("t1Lda", {28'd0, irOnAdr, memBus.mem_rd, ldAc, passAdd}, 32'hE);
    checkOutput("t1LdaAdr", 32'(adr), 32'd5);
    staCycles = 0;
    sawLdPc   = 1'b0;
    budget    = 40;
    while (expQ.size() > 0 && budget > 0) begin
      stepCycle();
      budget--;
      if (passAdd) begin
        checkOutput("addLdAc", {31'd0, ldAc}, 32'd1);
        checkOutput("addNoMem", {28'd0, memBus.mem_rd, memBus.mem_wr, irOnAdr, pcOnAdr}, 32'd0);
      end
      if (memBus.mem_wr) begin
        staCycles++;
        checkOutput("staIrAdr", {31'd0, irOnAdr}, 32'd1);
      end
      if (sawLdPc) begin
        checkOutput("jmpFetchPc", {25'd0, pcOnAdr, adr}, {25'd0, 1'b1, 6'd3});
        sawLdPc = 1'b0;
      end
      if (ldPc) sawLdPc = 1'b1;
    end
    checkOutput("t1Drained", 32'(expQ.size()), 32'd0);
    checkOutput("staOneCycle", 32'(staCycles), 32'd1);

    $display("[TB] fetch with three wait cycles");
    applyStimulus(2);
    doReset();
    readyDrive = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("waitRd", {31'd0, memBus.mem_rd}, 32'd1);
      checkOutput("waitNoLdIr", {31'd0, ldIr}, 32'd0);
    end
    readyDrive = 1'b1;
    #1;
    checkOutput("waitReadyLdIr", {30'd0, memBus.mem_rd, ldIr}, 32'h3);
    stepCycle();
    checkOutput("waitDecode", {30'd0, incPc, fault}, 32'h2);
    budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      stepCycle();
      budget--;
    end
    checkOutput("t2Drained", 32'(expQ.size()), 32'd0);
    checkOutput("t2NoFault", {31'd0, fault}, 32'd0);

    $display("[TB] memory timeout during LDA");
    applyStimulus(3);
    doReset();
    stepCycle();
    stepCycle();
    readyDrive = 1'b0;
    stepCycle();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      checkOutput("ldaWaitRd", {31'd0, memBus.mem_rd}, 32'd1);
      checkOutput("ldaNoLdAc", {31'd0, ldAc}, 32'd0);
      checkOutput("ldaNoFaultYet", {31'd0, fault}, 32'd0);
      stepCycle();
    end
    checkOutput("faultSet", {31'd0, fault}, 32'd1);
    checkOutput("faultStrobes", {22'd0, irOnAdr, pcOnAdr, ldIr, ldAc, ldPc, incPc, clrPc, passAdd,
                                 memBus.mem_rd, memBus.mem_wr}, 32'd0);
    readyDrive = 1'b1;
    repeat (3) stepCycle();
    checkOutput("faultSticky", {31'd0, fault}, 32'd1);
    checkOutput("faultAcUntouched", 32'(acM), 32'h2A);
    rst = 1'b1;
    #1;
    checkOutput("faultClearedByRst", {31'd0, fault}, 32'd0);
    checkOutput("faultRstClrPc", {31'd0, clrPc}, 32'd1);
    checkOutput("faultRstCount", 32'(instrCount), 32'd0);

    $display("[TB] asynchronous reset in the middle of STA");
    applyStimulus(4);
    doReset();
    budget = 30;
    while (!memBus.mem_wr && budget > 0) begin
      stepCycle();
      budget--;
    end
    checkOutput("reachedSta", {31'd0, memBus.mem_wr}, 32'd1);
    checkOutput("staCountBefore", 32'(instrCount), 32'd2);
    checkOutput("t4Drained", 32'(expQ.size()), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstWr", {31'd0, memBus.mem_wr}, 32'd0);
    checkOutput("asyncRstIrAdr", {31'd0, irOnAdr}, 32'd0);
    checkOutput("asyncRstClrPc", {31'd0, clrPc}, 32'd1);
    checkOutput("asyncRstCount", 32'(instrCount), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("asyncRstPc", 32'(pcM), 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
